// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one memory between the fetch port (i_*) and the load/store port
// (d_*). Each request gets a one-cycle grant, then exactly one memory access
// runs at a time. Completion is signalled by a one-cycle rvalid pulse on the
// port that owned the access.
//
// Parameters
//   ADDR_WIDTH   word address width of the shared memory
//   DATA_WIDTH   data word width
//   MEM_LATENCY  cycles from address on m_addr to m_rdata valid (1..15)
//
// Ports
//   clk, reset            clock and synchronous active-high reset
//   i_req/i_addr          fetch request, held until i_gnt
//   i_gnt                 one-cycle fetch grant (combinational)
//   i_rvalid/i_rdata      fetch completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata   load/store request, held until d_gnt
//   d_gnt                 one-cycle load/store grant (combinational)
//   d_rvalid/d_rdata      load/store completion pulse and load data
//   m_addr/m_we/m_wdata   registered memory command
//   m_rdata               memory read data
//
// Timing with L = MEM_LATENCY: grant in cycle 0, memory command valid in
// cycles 1..L, rvalid in cycle L+1. A new grant can be issued in cycle L+1.
// ---------------------------------------------------------------------------
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_we,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Owner / last-granted encoding: 0 = fetch port, 1 = load/store port.
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  // The counter is loaded with L-1 so that it reaches zero in the last
  // cycle the memory command is presented.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t                state_q,    state_d;
  logic [3:0]            cnt_q,      cnt_d;
  logic                  last_q,     last_d;
  logic                  owner_q,    owner_d;
  logic                  owner_we_q, owner_we_d;
  logic                  i_rvalid_q, i_rvalid_d;
  logic                  d_rvalid_q, d_rvalid_d;
  logic [DATA_WIDTH-1:0] i_rdata_q,  i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q,  d_rdata_d;
  logic [ADDR_WIDTH-1:0] m_addr_q,   m_addr_d;
  logic                  m_we_q,     m_we_d;
  logic [DATA_WIDTH-1:0] m_wdata_q,  m_wdata_d;

  logic grant_i;
  logic grant_d;

  // Round-robin grant: a lone request wins outright; on a tie the port that
  // was not granted last time wins. Grants are suppressed while reset is
  // asserted so that no grant is shown for an access that will not happen.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE && !reset) begin
      if (i_req && d_req) begin
        if (last_q == OWNER_I) begin
          grant_d = 1'b1;
        end else begin
          grant_i = 1'b1;
        end
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    owner_d    = owner_q;
    owner_we_d = owner_we_q;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    m_addr_d   = m_addr_q;
    m_we_d     = m_we_q;
    m_wdata_d  = m_wdata_q;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          // Fetches never write; m_wdata keeps its previous value.
          owner_d    = OWNER_I;
          owner_we_d = 1'b0;
          last_d     = OWNER_I;
          m_addr_d   = i_addr;
          m_we_d     = 1'b0;
          cnt_d      = CNT_INIT;
          state_d    = ACCESS;
        end else if (grant_d) begin
          owner_d    = OWNER_D;
          owner_we_d = d_we;
          last_d     = OWNER_D;
          m_addr_d   = d_addr;
          m_we_d     = d_we;
          m_wdata_d  = d_wdata;
          cnt_d      = CNT_INIT;
          state_d    = ACCESS;
        end
      end

      ACCESS: begin
        // The write strobe lasts only for the first access cycle; address
        // and write data stay put for the whole access.
        m_we_d = 1'b0;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
          if (owner_q == OWNER_I) begin
            i_rdata_d  = m_rdata;
            i_rvalid_d = 1'b1;
          end else begin
            if (!owner_we_q) begin
              d_rdata_d = m_rdata;
            end
            d_rvalid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. Reset aborts any access in flight: no rvalid follows
  // and the write strobe drops on the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      last_q     <= OWNER_I;
      owner_q    <= OWNER_I;
      owner_we_q <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      m_addr_q   <= '0;
      m_we_q     <= 1'b0;
      m_wdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      owner_we_q <= owner_we_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      m_addr_q   <= m_addr_d;
      m_we_q     <= m_we_d;
      m_wdata_q  <= m_wdata_d;
    end
  end

  assign i_gnt    = grant_i;
  assign d_gnt    = grant_d;
  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign m_addr   = m_addr_q;
  assign m_we     = m_we_q;
  assign m_wdata  = m_wdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for unified_mem_arbiter. Two instances run side by side, one with a
// memory latency of 1 and one with 3, each attached to its own simple memory
// and its own transaction-level reference model. Each lane starts with a few
// directed phases (tie alternation, store aborted by reset, load-back, fetch
// of a known word) and then switches to random traffic with occasional reset.
// ---------------------------------------------------------------------------
module tb_unified_mem_arbiter;

   localparam int AW   = 6;
   localparam int DW   = 32;
   localparam int NCYC = 2500;

   logic clk = 1'b0;
   int   assertCount = 0;
   int   failCount   = 0;

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Power-up contents of every memory; address 5 holds a recognisable word.
   function automatic logic [DW-1:0] initWord(input int a);
      if (a == 5) return 32'hDEADBEEF;
      return 32'hA5A5_0000 | 32'(a * 17);
   endfunction

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                              input logic [DW-1:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=%h expected=%h at t=%0t", tag, observed, expected, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int LAT     = (g == 0) ? 1 : 3;
      localparam int TIE_END = 3 + 4 * (LAT + 1) + 4;

      logic          reset;
      logic          iReq;
      logic [AW-1:0] iAddr;
      logic          iGnt;
      logic          iRvalid;
      logic [DW-1:0] iRdata;
      logic          dReq;
      logic          dWe;
      logic [AW-1:0] dAddr;
      logic [DW-1:0] dWdata;
      logic          dGnt;
      logic          dRvalid;
      logic [DW-1:0] dRdata;
      logic [AW-1:0] mAddr;
      logic          mWe;
      logic [DW-1:0] mWdata;
      logic [DW-1:0] mRdata;
      logic          memInit;
      logic [DW-1:0] mem [2**AW];
      bit            done = 1'b0;

      unified_mem_arbiter #(
         .ADDR_WIDTH (AW),
         .DATA_WIDTH (DW),
         .MEM_LATENCY(LAT)
      ) dut (
         .clk     (clk),
         .reset   (reset),
         .i_req   (iReq),
         .i_addr  (iAddr),
         .i_gnt   (iGnt),
         .i_rvalid(iRvalid),
         .i_rdata (iRdata),
         .d_req   (dReq),
         .d_we    (dWe),
         .d_addr  (dAddr),
         .d_wdata (dWdata),
         .d_gnt   (dGnt),
         .d_rvalid(dRvalid),
         .d_rdata (dRdata),
         .m_addr  (mAddr),
         .m_we    (mWe),
         .m_wdata (mWdata),
         .m_rdata (mRdata)
      );

      // Memory: synchronous write, read data follows the held address.
      always @(posedge clk) begin
         if (memInit) begin
            for (int k = 0; k < 2**AW; k++) mem[k] <= initWord(k);
         end else if (mWe) begin
            mem[mAddr] <= mWdata;
         end
      end
      assign mRdata = mem[mAddr];

      // Reference model: one access at a time, described by its grant cycle.
      logic [DW-1:0] refMem [2**AW];
      bit            modelValid;
      bit            active;
      bit            accOwnerD;
      bit            accWe;
      bit            lastD;
      bit            doneOwnerD;
      bit            predIG;
      bit            predDG;
      int            grantCyc;
      int            doneCyc;
      logic [AW-1:0] accAddr;
      logic [AW-1:0] expMAddr;
      logic [DW-1:0] accWdata;
      logic [DW-1:0] expIRdata;
      logic [DW-1:0] expDRdata;

      task automatic applyStimulus(input int cyc);
         reset   = 1'b0;
         memInit = 1'b0;
         iReq    = 1'b0;
         iAddr   = '0;
         dReq    = 1'b0;
         dWe     = 1'b0;
         dAddr   = '0;
         dWdata  = '0;
         if (cyc < 3) begin
            reset   = 1'b1;
            memInit = (cyc == 0);
         end else if (cyc < TIE_END) begin
            iReq  = 1'b1;
            iAddr = 6'd1;
            dReq  = 1'b1;
            dAddr = 6'd2;
         end else if (cyc == TIE_END) begin
            reset = 1'b1;
         end else if (cyc <= TIE_END + 2) begin
            dReq   = 1'b1;
            dWe    = 1'b1;
            dAddr  = 6'd3;
            dWdata = 32'h12345678;
         end else if (cyc == TIE_END + 3) begin
            reset = 1'b1;
         end else if (cyc <= TIE_END + 5 + LAT) begin
            dReq  = 1'b1;
            dAddr = 6'd3;
         end else if (cyc <= TIE_END + 8 + 2 * LAT) begin
            iReq  = 1'b1;
            iAddr = 6'd5;
         end else begin
            reset  = ($urandom_range(0, 249) == 0);
            iReq   = ($urandom_range(0, 99) < 55);
            iAddr  = AW'($urandom_range(0, 7));
            dReq   = ($urandom_range(0, 99) < 55);
            dWe    = 1'($urandom_range(0, 1));
            dAddr  = AW'($urandom_range(0, 7));
            dWdata = $urandom();
         end
      endtask

      // Arbitration rule: free memory, not in reset, lone request wins,
      // a tie goes to the port that was not served last.
      task automatic predictGrants();
         predIG = 1'b0;
         predDG = 1'b0;
         if (!reset && !active) begin
            if (iReq && dReq) begin
               predDG = !lastD;
               predIG = lastD;
            end else begin
               predIG = iReq;
               predDG = dReq;
            end
         end
      endtask

      task automatic checkCycle(input int cyc);
         string pfx;
         bit    expWe;
         pfx   = $sformatf("L%0d ", LAT);
         expWe = active && (cyc == grantCyc + 1) && accWe;
         checkOutput({pfx, "i_gnt"},    DW'(iGnt),    DW'(predIG));
         checkOutput({pfx, "d_gnt"},    DW'(dGnt),    DW'(predDG));
         checkOutput({pfx, "i_rvalid"}, DW'(iRvalid), DW'(doneCyc == cyc && !doneOwnerD));
         checkOutput({pfx, "d_rvalid"}, DW'(dRvalid), DW'(doneCyc == cyc && doneOwnerD));
         checkOutput({pfx, "i_rdata"},  iRdata,       expIRdata);
         checkOutput({pfx, "d_rdata"},  dRdata,       expDRdata);
         checkOutput({pfx, "m_addr"},   DW'(mAddr),   DW'(expMAddr));
         checkOutput({pfx, "m_we"},     DW'(mWe),     DW'(expWe));
         if (expWe) checkOutput({pfx, "m_wdata"}, mWdata, accWdata);
      endtask

      // Advance the model across the clock edge that ends cycle cyc.
      task automatic stepModel(input int cyc);
         if (reset) begin
            modelValid = 1'b1;
            active     = 1'b0;
            doneCyc    = -1;
            lastD      = 1'b0;
            expMAddr   = '0;
            expIRdata  = '0;
            expDRdata  = '0;
         end else if (modelValid) begin
            if (active && cyc == grantCyc + LAT) begin
               active     = 1'b0;
               doneCyc    = cyc + 1;
               doneOwnerD = accOwnerD;
               if (!accWe) begin
                  if (accOwnerD) expDRdata = refMem[accAddr];
                  else           expIRdata = refMem[accAddr];
               end
            end else if (predIG) begin
               active    = 1'b1;
               grantCyc  = cyc;
               accOwnerD = 1'b0;
               accAddr   = iAddr;
               accWe     = 1'b0;
               lastD     = 1'b0;
               expMAddr  = iAddr;
            end else if (predDG) begin
               active    = 1'b1;
               grantCyc  = cyc;
               accOwnerD = 1'b1;
               accAddr   = dAddr;
               accWe     = dWe;
               accWdata  = dWdata;
               lastD     = 1'b1;
               expMAddr  = dAddr;
               // A strobed write reaches memory even if reset follows.
               if (dWe) refMem[dAddr] = dWdata;
            end
         end
      endtask

      initial begin
         modelValid = 1'b0;
         active     = 1'b0;
         doneCyc    = -1;
         grantCyc   = 0;
         lastD      = 1'b0;
         doneOwnerD = 1'b0;
         accWe      = 1'b0;
         accOwnerD  = 1'b0;
         accAddr    = '0;
         accWdata   = '0;
         expMAddr   = '0;
         expIRdata  = '0;
         expDRdata  = '0;
         for (int k = 0; k < 2**AW; k++) refMem[k] = initWord(k);
         applyStimulus(0);
         for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            applyStimulus(cyc);
            #1;
            predictGrants();
            if (modelValid) checkCycle(cyc);
            stepModel(cyc);
         end
         done = 1'b1;
      end
   end

   initial begin
      wait (lane[0].done && lane[1].done);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #(NCYC * 10 * 2 + 1000);
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one unified instruction/data memory between the instruction-fetch port and the load/store port of the CPU.
- Sits between the core and a single memory instance; replaces the separate imem/dmem buses when the board uses a single shared memory.
- Arbitrates fairly, sequences one memory access at a time, and returns read data through a per-port valid pulse.

Parameters:
ADDR_WIDTH, 6, word address width of the shared memory
DATA_WIDTH, 32, data word width
MEM_LATENCY, 1, cycles from address presented on m_addr to m_rdata valid; legal range 1..15

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
i_req  in  1  fetch request; held with i_addr until i_gnt
i_addr  in  ADDR_WIDTH  fetch word address
i_gnt  out  1  one-cycle grant; request accepted this cycle
i_rvalid  out  1  one-cycle pulse; i_rdata valid
i_rdata  out  DATA_WIDTH  fetched word, held until next fetch completion
d_req  in  1  load/store request; held with d_we/d_addr/d_wdata until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_WIDTH  load/store word address
d_wdata  in  DATA_WIDTH  store data
d_gnt  out  1  one-cycle grant
d_rvalid  out  1  one-cycle completion pulse (load data or store ack)
d_rdata  out  DATA_WIDTH  load data; unchanged on store completion
m_addr  out  ADDR_WIDTH  memory address (registered)
m_we  out  1  memory write enable (registered)
m_wdata  out  DATA_WIDTH  memory write data (registered)
m_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset; there is one clock domain.
- Reset values: state=IDLE, cnt=0, last=I (data wins the first tie), gnts=0, rvalids=0, i_rdata=d_rdata=0, m_addr=0, m_we=0, m_wdata=0.
- FSM states are IDLE and ACCESS. cnt width is 4 bits.
- IDLE:
  - Grants are combinational from state, req and last.
  - With only one request, grant it. With both, grant the port not equal to last (round-robin).
  - On a grant edge: latch owner, addr, we and wdata into m_addr/m_we/m_wdata; set last=owner; cnt=MEM_LATENCY-1; go to ACCESS.
  - Fetch grants always latch we=0.
- ACCESS:
  - m_addr and m_wdata are held; m_we is high only in the first ACCESS cycle.
  - No grants are issued.
  - Decrement cnt each cycle. At an edge where cnt==0:
    - if the owner performed a load or fetch, capture m_rdata into the owner's rdata register;
    - pulse the owner's rvalid in the next cycle;
    - m_we=0; return to IDLE.
- Timing with L=MEM_LATENCY:
  - gnt in cycle 0; m_* valid in cycles 1..L; rvalid in cycle L+1.
  - A new grant may occur in cycle L+1 alongside rvalid, so peak throughput is one access per L+1 cycles.
- A requester may drop req before gnt (withdrawal); no access occurs. Requests are not queued inside the block.
- req/addr changes while not granted are ignored. Inputs are sampled only in the grant cycle.
- Starvation: with both ports continuously requesting, grants strictly alternate I, D, I, D, starting with D after reset.
- Reset asserted mid-ACCESS aborts the access: no rvalid, m_we=0 next cycle. A write already strobed may have been committed to memory.
- Outputs never show X after reset; rdata registers are cleared only by reset.

Test Plan:
- L=1, mem[5]=0xDEADBEEF, i_req with i_addr=5 held -> i_gnt in cycle 0; m_addr=5 in cycle 1; i_rvalid and i_rdata=0xDEADBEEF in cycle 2; no d_* activity.
- L=1, store d_addr=3, d_wdata=0x12345678, then load d_addr=3 -> m_we high for exactly 1 cycle; store ack d_rvalid leaves d_rdata unchanged; load returns 0x12345678.
- Both ports request every cycle from reset (I addr 1, D addr 2) -> grant order D, I, D, I; m_addr sequence 2, 1, 2, 1 spaced L+1 cycles apart.
- L=3, single fetch -> i_gnt cycle 0; m_addr stable in cycles 1-3; i_rvalid in cycle 4; next grant possible in cycle 4.
- Store in flight (L=3); reset asserted in cycle 2 -> no d_rvalid; all outputs return to reset values the next cycle; first tie after reset is granted to D.
- i_req pulsed for one cycle during D's ACCESS, then dropped -> no I grant and no access issued; FSM returns to IDLE after D completes.
